// File: rtl/dense_input_framer_pkg.sv
// Shared types and constants for the dense-layer input framer.
package dense_input_framer_pkg;

  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

  localparam int DEFAULT_WIDTH = 17;
  typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;

  // Dense layer pipeline: systolic array, adder tree over 32 inputs, output register.
  localparam int SA_DEPTH              = 2;
  localparam int ADDER_TREE_DEPTH      = 5;
  localparam int OUT_REG_DEPTH         = 1;
  localparam int DEFAULT_LAYER_LATENCY = SA_DEPTH + ADDER_TREE_DEPTH + OUT_REG_DEPTH;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_input_framer_valid_delay_line.sv
// Fixed-depth shift register for {valid, tag}; clear drops everything in flight.
module valid_delay_line #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data
);

  logic [W-1:0] pipe_q [DEPTH];
  logic [W-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (clear) pipe_q <= '{default: '0};
    else       pipe_q <= pipe_d;
  end

  assign out_data = pipe_q[DEPTH-1];

endmodule

// File: rtl/dense_input_framer.sv
// Collects INPUT_SIZE serial samples into a registered vector for the dense layer,
// enforces a minimum issue spacing and tracks the matching layer output cycle.
//   state | meaning
//   FILL  | accepting samples into the shadow buffer
//   WAIT  | full frame held, waiting for the gap counter to expire
module dense_input_framer
  import dense_input_framer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int INPUT_SIZE    = 32,
  parameter int LAYER_LATENCY = DEFAULT_LAYER_LATENCY,
  parameter int MIN_GAP       = 1,
  parameter int TAG_W         = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] vec_data [0:INPUT_SIZE-1],
  output logic                    vec_valid,
  output logic [TAG_W-1:0]        vec_tag,
  output logic                    layer_out_valid,
  output logic [TAG_W-1:0]        layer_out_tag,
  output logic                    busy
);

  localparam int CNT_W = $clog2(INPUT_SIZE + 1);
  localparam int IDX_W = clog2_min1(INPUT_SIZE);
  localparam int GAP_W = clog2_min1(MIN_GAP);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(INPUT_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(INPUT_SIZE);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic signed [WIDTH-1:0] shadow_q [0:INPUT_SIZE-1];
  logic signed [WIDTH-1:0] shadow_d [0:INPUT_SIZE-1];
  logic signed [WIDTH-1:0] vec_data_q [0:INPUT_SIZE-1];
  logic signed [WIDTH-1:0] vec_data_d [0:INPUT_SIZE-1];
  logic                    vec_valid_q, vec_valid_d;
  logic [TAG_W-1:0]        vec_tag_q, vec_tag_d;
  logic                    accept;
  logic                    issue;
  logic [TAG_W:0]          dly_out;

  assign in_ready = !reset && (state_q == FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tag_d       = tag_q;
    shadow_d    = shadow_q;
    vec_data_d  = vec_data_q;
    vec_valid_d = 1'b0;
    vec_tag_d   = vec_tag_q;
    gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    issue       = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          shadow_d[count_q[IDX_W-1:0]] = in_data;
          if (count_q == LAST_IDX) begin
            if (gap_q == '0) begin
              issue = 1'b1;
            end else begin
              state_d = WAIT;
              count_d = FULL_CNT;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (gap_q == '0) begin
          issue   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    // shadow_d already holds the last sample when issuing straight from FILL
    if (issue) begin
      vec_data_d  = shadow_d;
      vec_valid_d = 1'b1;
      vec_tag_d   = tag_q;
      tag_d       = tag_q + 1'b1;
      count_d     = '0;
      gap_d       = GAP_RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      gap_q       <= '0;
      tag_q       <= '0;
      shadow_q    <= '{default: '0};
      vec_data_q  <= '{default: '0};
      vec_valid_q <= 1'b0;
      vec_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      tag_q       <= tag_d;
      shadow_q    <= shadow_d;
      vec_data_q  <= vec_data_d;
      vec_valid_q <= vec_valid_d;
      vec_tag_q   <= vec_tag_d;
    end
  end

  valid_delay_line #(
    .DEPTH (LAYER_LATENCY),
    .W     (TAG_W + 1)
  ) u_delay (
    .clk      (clk),
    .clear    (reset),
    .in_data  ({vec_valid_q, vec_tag_q}),
    .out_data (dly_out)
  );

  assign vec_data        = vec_data_q;
  assign vec_valid       = vec_valid_q;
  assign vec_tag         = vec_tag_q;
  assign layer_out_valid = dly_out[TAG_W];
  assign layer_out_tag   = dly_out[TAG_W-1:0];
  assign busy            = (count_q != '0) || (state_q == WAIT);

endmodule
